// File: rtl/perf_ctr_pkg.sv
// Shared encodings for the performance-counter arbiter: command ops, FSM states,
// and the counter slave's register map.
package perf_ctr_pkg;

  typedef enum logic [1:0] {
    OP_START = 2'd0,
    OP_STOP  = 2'd1,
    OP_CLEAR = 2'd2,
    OP_READ  = 2'd3
  } op_e;

  typedef enum logic [3:0] {
    IDLE, WR, RD_HI, RD_LO, RD_HI2, RD_EV, RD_EVCAP, RD_LO2, RD_LO2CAP, RESP
  } state_e;

  localparam logic [2:0] OFS_TLO    = 3'd0;
  localparam logic [2:0] OFS_THI    = 3'd1;
  localparam logic [2:0] OFS_EV     = 3'd2;
  localparam logic [2:0] SEC_STRIDE = 3'd4;

  function automatic logic [2:0] sec_addr(input logic sec, input logic [2:0] ofs);
    return (sec ? SEC_STRIDE : 3'd0) + ofs;
  endfunction

endpackage

// File: rtl/perf_ctr_arbiter_rr.sv
// Combinational round-robin picker: first asserted request strictly after ptr_i,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  logic [ID_W-1:0] cand;
  logic            found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(ptr_i) + i) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/perf_ctr_arbiter.sv
// Round-robin front end for the shared performance-counter slave: issues writes
// for START/STOP/CLEAR and a tear-free hi/lo/hi/ev multi-read for READ.
module perf_ctr_arbiter
  import perf_ctr_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [2*NUM_REQ-1:0] req_op,
  input  logic [NUM_REQ-1:0]   req_sec,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 busy,
  output logic                 resp_valid,
  output logic [ID_W-1:0]      resp_id,
  output logic [63:0]          resp_time,
  output logic [31:0]          resp_events,
  output logic [2:0]           pc_address,
  output logic                 pc_write,
  output logic                 pc_begintransfer,
  output logic [31:0]          pc_writedata,
  input  logic [31:0]          pc_readdata
);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, id_q, win_idx;
  logic [NUM_REQ-1:0] win_gnt;
  logic               win_any, accept;
  logic [1:0]         win_op;
  op_e                op_q;
  logic               sec_q;
  logic [31:0]        hi1_q, lo_q, hi2_q, ev_q, events_q;
  logic [63:0]        time_q;
  logic [2:0]         addr_q, addr_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  assign win_op = req_op[{win_idx, 1'b0} +: 2];
  assign accept = (state_q == IDLE) && win_any;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept) state_d = (op_e'(win_op) == OP_READ) ? RD_HI : WR;
      WR:        state_d = RESP;
      RD_HI:     state_d = RD_LO;
      RD_LO:     state_d = RD_HI2;
      RD_HI2:    state_d = RD_EV;
      RD_EV:     state_d = RD_EVCAP;
      // A changed hi word means lo wrapped between reads: fetch lo again under hi2.
      RD_EVCAP:  state_d = (hi2_q == hi1_q) ? RESP : RD_LO2;
      RD_LO2:    state_d = RD_LO2CAP;
      RD_LO2CAP: state_d = RESP;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d       = addr_q;
    pc_write     = 1'b0;
    pc_writedata = '0;
    case (state_q)
      WR: begin
        pc_write = 1'b1;
        if (op_q == OP_CLEAR) begin
          addr_d       = 3'd0;
          pc_writedata = 32'd1;
        end else begin
          addr_d = sec_addr(sec_q, (op_q == OP_START) ? OFS_THI : OFS_TLO);
        end
      end
      RD_HI, RD_HI2: addr_d = sec_addr(sec_q, OFS_THI);
      RD_LO, RD_LO2: addr_d = sec_addr(sec_q, OFS_TLO);
      RD_EV:         addr_d = sec_addr(sec_q, OFS_EV);
      default:       ;
    endcase
  end

  assign pc_address       = addr_d;
  assign pc_begintransfer = pc_write;
  assign busy             = (state_q != IDLE);
  assign resp_valid       = (state_q == RESP);
  assign resp_id          = id_q;
  assign resp_time        = time_q;
  assign resp_events      = events_q;
  assign req_ready        = (reset_n && state_q == IDLE) ? win_gnt : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q    <= ID_W'(NUM_REQ - 1);
      id_q     <= '0;
      op_q     <= OP_START;
      sec_q    <= 1'b0;
      addr_q   <= '0;
      hi1_q    <= '0;
      lo_q     <= '0;
      hi2_q    <= '0;
      ev_q     <= '0;
      time_q   <= '0;
      events_q <= '0;
    end else begin
      addr_q <= addr_d;
      if (accept) begin
        ptr_q <= win_idx;
        id_q  <= win_idx;
        op_q  <= op_e'(win_op);
        sec_q <= req_sec[win_idx];
      end
      // Slave read data is registered: each capture takes the previous cycle's address.
      case (state_q)
        WR: begin
          time_q   <= '0;
          events_q <= '0;
        end
        RD_LO:  hi1_q <= pc_readdata;
        RD_HI2: lo_q  <= pc_readdata;
        RD_EV:  hi2_q <= pc_readdata;
        RD_EVCAP: begin
          ev_q <= pc_readdata;
          if (hi2_q == hi1_q) begin
            time_q   <= {hi1_q, lo_q};
            events_q <= pc_readdata;
          end
        end
        RD_LO2CAP: begin
          lo_q     <= pc_readdata;
          time_q   <= {hi2_q, pc_readdata};
          events_q <= ev_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_perf_ctr_arbiter.sv
// Directed bench for perf_ctr_arbiter with a registered-read counter slave model.
module tb_perf_ctr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [2*NUM_REQ-1:0] req_op = '0;
  logic [NUM_REQ-1:0]   req_sec = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 busy, resp_valid;
  logic [ID_W-1:0]      resp_id;
  logic [63:0]          resp_time;
  logic [31:0]          resp_events;
  logic [2:0]           pc_address;
  logic                 pc_write, pc_begintransfer;
  logic [31:0]          pc_writedata;
  logic [31:0]          pc_readdata;
  logic [31:0]          mem [0:7];

  int tests = 0;
  int fails = 0;

  perf_ctr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_op           (req_op),
    .req_sec          (req_sec),
    .req_ready        (req_ready),
    .busy             (busy),
    .resp_valid       (resp_valid),
    .resp_id          (resp_id),
    .resp_time        (resp_time),
    .resp_events      (resp_events),
    .pc_address       (pc_address),
    .pc_write         (pc_write),
    .pc_begintransfer (pc_begintransfer),
    .pc_writedata     (pc_writedata),
    .pc_readdata      (pc_readdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pc_readdata <= mem[pc_address];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [1:0] op, input logic sec);
    req_valid[id]      = 1'b1;
    req_op[2*id +: 2]  = op;
    req_sec[id]        = sec;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rvalid"}, resp_valid, 0);
    chk({tag, "_rid"}, resp_id, 0);
    chk({tag, "_rtime"}, resp_time, 0);
    chk({tag, "_rev"}, resp_events, 0);
    chk({tag, "_addr"}, pc_address, 0);
    chk({tag, "_wr"}, pc_write, 0);
    chk({tag, "_bt"}, pc_begintransfer, 0);
    chk({tag, "_wdata"}, pc_writedata, 0);
  endtask

  // READ from one requester; with tear set, the slave's hi word steps 1->2 after
  // the first hi read and lo becomes 5 after the first lo read.
  task automatic read_cmd(input int id, input logic sec, input bit tear,
                          input logic [63:0] exp_time, input logic [31:0] exp_ev);
    logic [2:0] b;
    b = sec ? 3'd4 : 3'd0;
    set_req(id, 2'd3, sec);
    #1;
    chk("rd_ready", req_ready, 4'b0001 << id);
    tick();
    req_valid = '0;
    chk("rd_addr_hi", pc_address, b + 3'd1);
    chk("rd_nowr1", pc_write, 0);
    tick();
    chk("rd_addr_lo", pc_address, b);
    if (tear) mem[b + 3'd1] = 32'h2;
    tick();
    chk("rd_addr_hi2", pc_address, b + 3'd1);
    if (tear) mem[b] = 32'h5;
    tick();
    chk("rd_addr_ev", pc_address, b + 3'd2);
    chk("rd_nowr2", pc_write, 0);
    tick();
    chk("rd_evcap_norv", resp_valid, 0);
    if (tear) begin
      tick();
      chk("rd_addr_lo2", pc_address, b);
      chk("rd_lo2_norv", resp_valid, 0);
      tick();
      chk("rd_lo2cap_norv", resp_valid, 0);
      chk("rd_nowr3", pc_write, 0);
    end
    tick();
    chk("rd_rvalid", resp_valid, 1);
    chk("rd_rid", resp_id, id);
    chk("rd_time", resp_time, exp_time);
    chk("rd_events", resp_events, exp_ev);
    tick();
    chk("rd_idle", busy, 0);
    chk("rd_rv_done", resp_valid, 0);
  endtask

  initial begin
    logic [1:0] order [6];
    order = '{2'd3, 2'd0, 2'd1, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 8; i++) mem[i] = '0;

    // Reset state
    tick();
    tick();
    chk_quiet("reset");
    reset_n = 1'b1;
    tick();

    // START sec 1 from requester 2
    set_req(2, 2'd0, 1'b1);
    #1;
    chk("start_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    chk("start_wr", pc_write, 1);
    chk("start_bt", pc_begintransfer, 1);
    chk("start_addr", pc_address, 5);
    chk("start_data", pc_writedata, 0);
    chk("start_busy", busy, 1);
    tick();
    chk("start_rvalid", resp_valid, 1);
    chk("start_rid", resp_id, 2);
    chk("start_rtime", resp_time, 0);
    chk("start_wr_off", pc_write, 0);
    tick();
    chk("start_idle", busy, 0);
    chk("start_addr_hold", pc_address, 5);

    // STOP sec 0 from 0,1,3 held continuously; pointer sits at 2
    set_req(0, 2'd1, 1'b0);
    set_req(1, 2'd1, 1'b0);
    set_req(3, 2'd1, 1'b0);
    #1;
    for (int k = 0; k < 6; k++) begin
      chk("rr_ready", req_ready, 4'b0001 << order[k]);
      tick();
      chk("rr_wr_noready", req_ready, 0);
      chk("rr_wr", pc_write, 1);
      chk("rr_addr", pc_address, 0);
      tick();
      chk("rr_rvalid", resp_valid, 1);
      chk("rr_rid", resp_id, order[k]);
      if (k == 5) req_valid = '0;
      tick();
    end

    // READ sec 0, stable counters
    mem[0] = 32'h8000_0000;
    mem[1] = 32'h1;
    mem[2] = 32'd7;
    read_cmd(2, 1'b0, 1'b0, 64'h0000_0001_8000_0000, 32'd7);

    // READ sec 1 with hi rolling over mid-sequence
    mem[4] = 32'hFFFF_FFFF;
    mem[5] = 32'h1;
    mem[6] = 32'd9;
    read_cmd(3, 1'b1, 1'b1, 64'h0000_0002_0000_0005, 32'd9);

    // CLEAR from requester 1, section ignored
    set_req(1, 2'd2, 1'b1);
    #1;
    chk("clr_ready", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    chk("clr_wr", pc_write, 1);
    chk("clr_addr", pc_address, 0);
    chk("clr_data", pc_writedata, 1);
    chk("clr_time_held", resp_time, 64'h0000_0002_0000_0005);
    tick();
    chk("clr_wr_single", pc_write, 0);
    chk("clr_rvalid", resp_valid, 1);
    chk("clr_rid", resp_id, 1);
    chk("clr_rtime", resp_time, 0);
    chk("clr_rev", resp_events, 0);
    tick();

    // Reset asserted during RD_EV of a READ from requester 1
    set_req(1, 2'd3, 1'b0);
    #1;
    chk("rst_rd_ready", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();
    chk("rst_in_rdev", pc_address, 2);
    reset_n = 1'b0;
    #1;
    chk_quiet("rst_async");
    tick();
    chk("rst_hold_rv", resp_valid, 0);
    chk("rst_hold_busy", busy, 0);
    reset_n = 1'b1;
    tick();
    chk("rst_after_rv", resp_valid, 0);
    req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 2'd1, 1'b0);
    #1;
    chk("rst_first_win", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    tick();
    chk("rst_first_rv", resp_valid, 1);
    chk("rst_first_rid", resp_id, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
